// File: rtl/bbpd_vote_acc.sv
// Multi-lane bang-bang phase detector with signed vote accumulation.
// Each enabled clock classifies LANES unit intervals as early, late or
// no-transition, sums the net vote, and fires a one-cycle up/down request
// when the accumulator reaches +/-THRESH. A transition-density watchdog
// raises no_trans after IDLE_MAX transition-free cycles and flushes the
// accumulator.
module bbpd_vote_acc #(
    parameter int LANES    = 4,
    parameter int ACC_W    = 8,
    parameter int THRESH   = 16,
    parameter int IDLE_MAX = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [LANES-1:0]        data_s,
    input  logic [LANES-1:0]        edge_s,
    output logic                    up,
    output logic                    down,
    output logic                    no_trans,
    output logic signed [ACC_W-1:0] acc
);

    localparam int CW = $clog2(LANES + 1);
    localparam int IW = $clog2(IDLE_MAX + 1);

    localparam logic signed [ACC_W-1:0] THR_POS = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] THR_NEG = -THR_POS;
    localparam logic [IW-1:0]           IDLE_LIM = IW'(IDLE_MAX);

    // Last centre bit of the previous enabled cycle, used by lane 0
    logic prevBit_q;

    // Stage-1 registers
    logic [CW-1:0] nUp_q;
    logic [CW-1:0] nDn_q;
    logic          s1Trans_q;
    logic          s1En_q;

    // Stage-2 registers
    logic signed [ACC_W-1:0] acc_q;
    logic                    up_q;
    logic                    down_q;
    logic                    noTrans_q;
    logic [IW-1:0]           idleCnt_q;

    // Combinational lane classification results
    logic [LANES-1:0] prevVec;
    logic [CW-1:0]    nUp_d;
    logic [CW-1:0]    nDn_d;
    logic             anyTrans_d;

    // Stage-2 next-state values
    logic signed [ACC_W-1:0] upExt;
    logic signed [ACC_W-1:0] dnExt;
    logic signed [ACC_W-1:0] sum;
    logic [IW-1:0]           idleCnt_d;
    logic                    flush;
    logic signed [ACC_W-1:0] acc_d;
    logic                    up_d;
    logic                    down_d;

    // Build the "previous centre bit" seen by each lane
    always_comb begin
        prevVec    = '0;
        prevVec[0] = prevBit_q;
        for (int i = 1; i < LANES; i++) begin
            prevVec[i] = data_s[i-1];
        end
    end

    // Count late and early votes; a lane votes only when its centre bit differs from the previous one
    always_comb begin
        nUp_d      = '0;
        nDn_d      = '0;
        anyTrans_d = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (prevVec[i] != data_s[i]) begin
                anyTrans_d = 1'b1;
                if (edge_s[i] == data_s[i]) begin
                    nUp_d = nUp_d + CW'(1);
                end else begin
                    nDn_d = nDn_d + CW'(1);
                end
            end
        end
    end

    // Stage 1: register vote counts and transition flag, gated by the enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prevBit_q <= 1'b0;
            nUp_q     <= '0;
            nDn_q     <= '0;
            s1Trans_q <= 1'b0;
            s1En_q    <= 1'b0;
        end else begin
            if (en) begin
                prevBit_q <= data_s[LANES-1];
            end
            nUp_q     <= en ? nUp_d : '0;
            nDn_q     <= en ? nDn_d : '0;
            s1Trans_q <= en & anyTrans_d;
            s1En_q    <= en;
        end
    end

    // Watchdog next count: clear on any transition, count transition-free enabled cycles up to the limit
    always_comb begin
        idleCnt_d = idleCnt_q;
        if (s1Trans_q) begin
            idleCnt_d = '0;
        end else if (s1En_q && (idleCnt_q < IDLE_LIM)) begin
            idleCnt_d = idleCnt_q + IW'(1);
        end
        flush = (idleCnt_d == IDLE_LIM) && (idleCnt_q != IDLE_LIM);
    end

    // Accumulate the net vote; a flush overrides the fire decision, and a fire restarts from zero
    always_comb begin
        upExt  = ACC_W'(nUp_q);
        dnExt  = ACC_W'(nDn_q);
        sum    = acc_q + upExt - dnExt;
        acc_d  = sum;
        up_d   = 1'b0;
        down_d = 1'b0;
        if (flush) begin
            acc_d = '0;
        end else if (sum >= THR_POS) begin
            acc_d = '0;
            up_d  = 1'b1;
        end else if (sum <= THR_NEG) begin
            acc_d  = '0;
            down_d = 1'b1;
        end
    end

    // Stage 2: accumulator, request pulses and starvation flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            noTrans_q <= 1'b0;
            idleCnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            up_q      <= up_d;
            down_q    <= down_d;
            noTrans_q <= (idleCnt_d == IDLE_LIM);
            idleCnt_q <= idleCnt_d;
        end
    end

    assign acc      = acc_q;
    assign up       = up_q;
    assign down     = down_q;
    assign no_trans = noTrans_q;

endmodule

// File: doc/bbpd_vote_acc.md
# bbpd_vote_acc

Parametrised multi-lane bang-bang phase detector with vote accumulation. Each clock it classifies LANES unit intervals of centre and edge samples, produced by the multi-phase sampler front end, as early, late or no-transition. It sums the net vote in a signed accumulator and emits a single-cycle up or down request to the phase controller when the accumulator crosses ±THRESH. A transition-density watchdog flags runs of data with no transitions and discards stale votes.

## Interface
- LANES, 4: UIs presented per clock, ≥1.
- ACC_W, 8: signed accumulator width. Legal only when THRESH + LANES ≤ 2^(ACC_W-1) − 1.
- THRESH, 16: fire threshold magnitude, ≥1.
- IDLE_MAX, 64: consecutive enabled no-transition cycles before no_trans asserts, ≥1.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  sample vectors valid this cycle.
- data_s  in  LANES  centre samples, bit 0 oldest UI.
- edge_s  in  LANES  edge samples. edge_s[i] lies between centre sample i−1 and centre sample i. For i=0, the previous centre sample is the stored last centre bit of the previous enabled cycle.
- up  out  1  one-cycle pulse: advance sampling phase.
- down  out  1  one-cycle pulse: retard sampling phase.
- no_trans  out  1  level: transition starvation.
- acc  out  ACC_W  signed accumulator value, for monitoring.

## Operation
- Per-lane classification, with p = previous centre bit and c = data_s[i]:
  - p≠c and edge_s[i]==c: late vote, contributes to up.
  - p≠c and edge_s[i]==p: early vote, contributes to down.
  - p==c: no vote, whatever the edge value (glitch edges are ignored).
  - At most one vote per lane.
- prev_bit register: loads data_s[LANES−1] on enabled cycles and holds when en=0. Reset value 0.
- Stage 1 registers, loaded every cycle:
  - n_up, n_dn: width $clog2(LANES+1), zero when en=0.
  - s1_trans: any lane has p≠c, gated by en.
  - s1_en: copy of en.
- Stage 2 computes a = acc + n_up − n_dn, signed, ACC_W bits.
  - a ≥ THRESH: up=1, acc←0.
  - a ≤ −THRESH: down=1, acc←0.
  - Otherwise acc←a, up=down=0.
  - No saturation is needed; the parameter constraint guarantees |a| ≤ THRESH−1+LANES.
- Watchdog counter idle_cnt, width $clog2(IDLE_MAX+1):
  - Clears when s1_trans=1.
  - Increments when s1_en=1, s1_trans=0 and idle_cnt<IDLE_MAX.
  - Holds when s1_en=0.
  - no_trans is registered and equals (idle_cnt_next == IDLE_MAX).
  - On the cycle idle_cnt_next first reaches IDLE_MAX, acc←0 (stale-vote flush). This takes priority over the fire evaluation; there are no votes in that cycle by definition.
- up and down are never both 1.
- Reset (async, any time): acc=0, up=0, down=0, no_trans=0, idle_cnt=0, prev_bit=0, all stage-1 registers 0. Operation resumes on the first rising edge after rst falls.

## Timing
- Inputs sampled at rising edge k are classified combinationally and registered into stage 1 at edge k.
- acc, up, down and no_trans update at edge k+1. Latency from samples to request is 2 edges.
- Throughput: one sample vector per clock. Consecutive fires are possible only when LANES ≥ THRESH.
- After a fire, acc=0 and the next vote starts from zero. There is no carry of the residual.
- en=0 for any number of cycles is transparent to the votes. The lane-0 comparison across the gap uses the last enabled data_s[LANES−1].
- no_trans deasserts at edge k+1 after the first enabled cycle k that contains a transition.
- A first enabled cycle after reset with data_s[0]=1 counts lane 0 as a transition against prev_bit=0. This is accepted behaviour.

## Test plan
- Reset mid-run: drive until acc=10, pulse rst between edges -> acc, up, down and no_trans read 0 immediately, before the next edge. After release, an all-zero input gives acc=0.
- Late data, LANES=4, THRESH=16: data_s=4'b0101 each cycle, edge_s=data_s -> 4 up votes per cycle. acc reads 4, 8, 12, then up=1 for one cycle at the 4th update with acc=0. Repeats every 4 cycles; down stays 0.
- Early data: data_s=4'b0101, edge_s={data_s[2:0],prev_bit} -> acc reads −4, −8, −12, then down=1 for one cycle with acc=0. up stays 0.
- Balanced: lanes 0–1 late, lanes 2–3 early, with transitions in all lanes -> acc stays 0, no pulses over 100 cycles.
- Starvation, IDLE_MAX=64: preload acc=12, then hold data_s=4'b1111 with prev_bit=1 for 64 enabled cycles -> no_trans rises with acc=0 at the 64th update. Then one cycle with a transition -> no_trans falls 2 edges later.
- Enable gaps: the alternating late pattern with en=0 on every other cycle -> up fires after 4 enabled cycles (8 clocks), proving that prev_bit holds across gaps and the idle counter is not advanced.
